posit_align_sequencer: RTL and testbench

//  Multi-cycle controller and datapath for posit addition alignment. Accepts decoded fields of two posits

---
 rtl/posit_align_sequencer.sv | 157 +++++++++++++++
 tb/tb_posit_align_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/posit_align_sequencer.sv
// Posit adder alignment stage: orders two decoded operands, aligns the smaller mantissa
// STEP bits per cycle with sticky collection, then adds or subtracts the aligned mantissas.
module posit_align_sequencer #(
   parameter int unsigned N    = 8,
   parameter int unsigned ES   = 3,
   parameter int unsigned RS   = $clog2(N),
   parameter int unsigned STEP = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N-2:0]      InRemain1,
   input  logic [N-2:0]      InRemain2,
   input  logic              Sign1,
   input  logic              Sign2,
   input  logic [RS:0]       RegimeValue1,
   input  logic [RS:0]       RegimeValue2,
   input  logic [ES-1:0]     Exponent1,
   input  logic [ES-1:0]     Exponent2,
   input  logic [N-ES+2:0]   Mantissa1,
   input  logic [N-ES+2:0]   Mantissa2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N-1:0]      E_diff,
   output logic [N-1:0]      Add_Mant,
   output logic              Res_Sign,
   output logic              Sticky
);

   localparam int unsigned MW     = N - ES + 3;
   localparam int unsigned CW     = $clog2(MW + 1);
   localparam int unsigned STEP_C = (STEP < MW) ? STEP : MW;
   localparam int unsigned AW     = (MW > N) ? MW : N;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StAlign = 2'd1,
      StAdd   = 2'd2,
      StDone  = 2'd3
   } state_e;

   state_e          r_state;
   logic            r_in_ready;
   logic            r_out_valid;
   logic [N-1:0]    r_e_diff;
   logic [N-1:0]    r_add_mant;
   logic            r_res_sign;
   logic            r_sticky;
   logic            r_op;
   logic [MW-1:0]   r_lm;
   logic [MW-1:0]   r_sm;
   logic [CW-1:0]   r_remain;

   logic            w_op1_larger;
   logic [RS:0]     w_rv_l;
   logic [RS:0]     w_rv_s;
   logic [ES-1:0]   w_e_l;
   logic [ES-1:0]   w_e_s;
   logic [MW-1:0]   w_m_l;
   logic [MW-1:0]   w_m_s;
   logic            w_sign_l;
   logic [N-1:0]    w_rv_diff;
   logic [N-1:0]    w_ediff;
   logic [CW-1:0]   w_shift;
   logic [CW-1:0]   w_step;
   logic [MW-1:0]   w_lost;
   logic [MW-1:0]   w_sm_next;
   logic [AW-1:0]   w_sum;

   // Operand ordering and exponent difference, evaluated against the live inputs in IDLE.
   always_comb begin
      w_op1_larger = (InRemain1 > InRemain2);
      w_rv_l       = w_op1_larger ? RegimeValue1 : RegimeValue2;
      w_rv_s       = w_op1_larger ? RegimeValue2 : RegimeValue1;
      w_e_l        = w_op1_larger ? Exponent1    : Exponent2;
      w_e_s        = w_op1_larger ? Exponent2    : Exponent1;
      w_m_l        = w_op1_larger ? Mantissa1    : Mantissa2;
      w_m_s        = w_op1_larger ? Mantissa2    : Mantissa1;
      w_sign_l     = w_op1_larger ? Sign1        : Sign2;
      w_rv_diff    = {{(N-RS-1){w_rv_l[RS]}}, w_rv_l} - {{(N-RS-1){w_rv_s[RS]}}, w_rv_s};
      w_ediff      = (w_rv_diff << ES) + N'(w_e_l) - N'(w_e_s);
      w_shift      = (w_ediff >= N'(MW)) ? CW'(MW) : CW'(w_ediff);
   end

   // One alignment step: at most STEP_C bits leave the smaller mantissa per cycle.
   always_comb begin
      w_step    = (r_remain > CW'(STEP_C)) ? CW'(STEP_C) : r_remain;
      w_lost    = r_sm & ~({MW{1'b1}} << w_step);
      w_sm_next = r_sm >> w_step;
      w_sum     = r_op ? (AW'(r_lm) - AW'(r_sm)) : (AW'(r_lm) + AW'(r_sm));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= StIdle;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_e_diff    <= '0;
         r_add_mant  <= '0;
         r_res_sign  <= 1'b0;
         r_sticky    <= 1'b0;
         r_op        <= 1'b0;
         r_lm        <= '0;
         r_sm        <= '0;
         r_remain    <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (in_valid && r_in_ready) begin
                  r_in_ready <= 1'b0;
                  r_e_diff   <= w_ediff;
                  r_res_sign <= w_sign_l;
                  r_op       <= Sign1 ^ Sign2;
                  r_lm       <= w_m_l;
                  r_sm       <= w_m_s;
                  r_remain   <= w_shift;
                  r_sticky   <= 1'b0;
                  r_state    <= (w_shift == '0) ? StAdd : StAlign;
               end
            end
            StAlign: begin
               r_sm     <= w_sm_next;
               r_sticky <= r_sticky | (|w_lost);
               r_remain <= r_remain - w_step;
               if (r_remain == w_step) begin
                  r_state <= StAdd;
               end
            end
            StAdd: begin
               r_add_mant  <= w_sum[N-1:0];
               r_out_valid <= 1'b1;
               r_state     <= StDone;
            end
            StDone: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= StIdle;
               end
            end
            default: begin
               r_state    <= StIdle;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign E_diff    = r_e_diff;
   assign Add_Mant  = r_add_mant;
   assign Res_Sign  = r_res_sign;
   assign Sticky    = r_sticky;

endmodule

// File: tb/tb_posit_align_sequencer.sv
// Directed bench for posit_align_sequencer (N=8, ES=3, STEP=2) with hand-computed results.
module tb_posit_align_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [6:0] InRemain1, InRemain2;
   logic       Sign1, Sign2;
   logic [3:0] RegimeValue1, RegimeValue2;
   logic [2:0] Exponent1, Exponent2;
   logic [7:0] Mantissa1, Mantissa2;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] E_diff;
   logic [7:0] Add_Mant;
   logic       Res_Sign;
   logic       Sticky;

   int n_checks = 0;
   int n_errors = 0;

   posit_align_sequencer #(.N(8), .ES(3), .STEP(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .InRemain1    (InRemain1),
      .InRemain2    (InRemain2),
      .Sign1        (Sign1),
      .Sign2        (Sign2),
      .RegimeValue1 (RegimeValue1),
      .RegimeValue2 (RegimeValue2),
      .Exponent1    (Exponent1),
      .Exponent2    (Exponent2),
      .Mantissa1    (Mantissa1),
      .Mantissa2    (Mantissa2),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .E_diff       (E_diff),
      .Add_Mant     (Add_Mant),
      .Res_Sign     (Res_Sign),
      .Sticky       (Sticky)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_ops(input logic [6:0] ir1, input logic [6:0] ir2, input logic s1,
                          input logic s2, input logic [3:0] rv1, input logic [3:0] rv2,
                          input logic [2:0] e1, input logic [2:0] e2, input logic [7:0] m1,
                          input logic [7:0] m2);
      InRemain1 = ir1; InRemain2 = ir2; Sign1 = s1; Sign2 = s2;
      RegimeValue1 = rv1; RegimeValue2 = rv2; Exponent1 = e1; Exponent2 = e2;
      Mantissa1 = m1; Mantissa2 = m2;
   endtask

   // Drives one operand set in a negedge-aligned cycle; returns #1 after the accepting edge.
   task automatic launch(input string tag);
      @(negedge clk);
      in_valid = 1'b1;
      check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // n_start edges since acceptance have already elapsed; latency counts edges to out_valid.
   task automatic wait_result(input string tag, input int n_start, input int lat,
                              input logic [7:0] ediff, input logic [7:0] add,
                              input logic sgn, input logic stk);
      int n = n_start;
      while (!out_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_latency"}, n, lat);
      check({tag, "_E_diff"}, {24'b0, E_diff}, {24'b0, ediff});
      check({tag, "_Add_Mant"}, {24'b0, Add_Mant}, {24'b0, add});
      check({tag, "_Res_Sign"}, {31'b0, Res_Sign}, {31'b0, sgn});
      check({tag, "_Sticky"}, {31'b0, Sticky}, {31'b0, stk});
   endtask

   task automatic finish_op(input string tag);
      @(posedge clk);
      #1;
      check({tag, "_idle_out_valid"}, {31'b0, out_valid}, 32'd0);
      check({tag, "_idle_in_ready"}, {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      logic [7:0] hold_ediff, hold_add;
      logic       hold_sgn, hold_stk;
      bit         seen;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      set_ops(7'h00, 7'h00, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0, 3'd0, 8'h00, 8'h00);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_E_diff", {24'b0, E_diff}, 32'd0);
      check("rst_Add_Mant", {24'b0, Add_Mant}, 32'd0);
      check("rst_Res_Sign", {31'b0, Res_Sign}, 32'd0);
      check("rst_Sticky", {31'b0, Sticky}, 32'd0);

      // Equal magnitudes: no shift, 0x40+0x40.
      set_ops(7'h40, 7'h40, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0, 3'd0, 8'h40, 8'h40);
      launch("equal");
      wait_result("equal", 1, 2, 8'd0, 8'h80, 1'b0, 1'b0);
      finish_op("equal");

      // Subtract: 0x90 - (0x88>>2 = 0x22) = 0x6E.
      set_ops(7'h48, 7'h44, 1'b0, 1'b1, 4'h0, 4'h0, 3'd3, 3'd1, 8'h90, 8'h88);
      launch("sub");
      wait_result("sub", 1, 3, 8'd2, 8'h6E, 1'b0, 1'b0);
      finish_op("sub");

      // Swap: larger is now op2, which carries sign 1.
      set_ops(7'h44, 7'h48, 1'b0, 1'b1, 4'h0, 4'h0, 3'd1, 3'd3, 8'h88, 8'h90);
      launch("swap");
      wait_result("swap", 1, 3, 8'd2, 8'h6E, 1'b1, 1'b0);
      finish_op("swap");

      // Sticky from a 2-bit shift: 0x83>>2 = 0x20, lost bits 2'b11.
      set_ops(7'h48, 7'h44, 1'b0, 1'b0, 4'h0, 4'h0, 3'd3, 3'd1, 8'h90, 8'h83);
      launch("stk2");
      wait_result("stk2", 1, 3, 8'd2, 8'hB0, 1'b0, 1'b1);
      finish_op("stk2");

      // Odd shift of 3 (steps 2 then 1): 0x8C>>3 = 0x11, lost 3'b100; 0x90+0x11.
      set_ops(7'h48, 7'h44, 1'b0, 1'b0, 4'h0, 4'h0, 3'd4, 3'd1, 8'h90, 8'h8C);
      launch("odd3");
      wait_result("odd3", 1, 4, 8'd3, 8'hA1, 1'b0, 1'b1);
      finish_op("odd3");

      // Saturated shift, with a competing operand set offered while busy (must be ignored).
      set_ops(7'h60, 7'h40, 1'b0, 1'b0, 4'h1, 4'h0, 3'd0, 3'd0, 8'h80, 8'h80);
      launch("sat");
      set_ops(7'h40, 7'h40, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0, 3'd0, 8'h40, 8'h40);
      in_valid = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      wait_result("sat", 3, 6, 8'd8, 8'h80, 1'b0, 1'b1);
      finish_op("sat");

      // Backpressure: result held for 5 cycles with out_ready low.
      out_ready = 1'b0;
      set_ops(7'h48, 7'h44, 1'b0, 1'b1, 4'h0, 4'h0, 3'd3, 3'd1, 8'h90, 8'h88);
      launch("bp");
      wait_result("bp", 1, 3, 8'd2, 8'h6E, 1'b0, 1'b0);
      hold_ediff = E_diff; hold_add = Add_Mant; hold_sgn = Res_Sign; hold_stk = Sticky;
      repeat (5) begin
         @(posedge clk);
         #1;
         check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
         check("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
         check("bp_hold_data", {15'b0, E_diff, Add_Mant, Res_Sign, Sticky},
               {15'b0, 8'd2, 8'h6E, 1'b0, 1'b0});
      end
      check("bp_hold_vs_first", {15'b0, E_diff, Add_Mant, Res_Sign, Sticky},
            {15'b0, hold_ediff, hold_add, hold_sgn, hold_stk});
      out_ready = 1'b1;
      finish_op("bp");

      // Reset in cycle T+2 of a saturated op.
      set_ops(7'h60, 7'h40, 1'b0, 1'b0, 4'h1, 4'h0, 3'd0, 3'd0, 8'h80, 8'h80);
      launch("rstmid");
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("rstmid_in_ready", {31'b0, in_ready}, 32'd1);
      check("rstmid_out_valid", {31'b0, out_valid}, 32'd0);
      check("rstmid_outputs", {15'b0, E_diff, Add_Mant, Res_Sign, Sticky}, 32'd0);
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      check("rstmid_no_result", {31'b0, seen}, 32'd0);

      // A fresh operation after the aborted one.
      set_ops(7'h40, 7'h40, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0, 3'd0, 8'h40, 8'h40);
      launch("post");
      wait_result("post", 1, 2, 8'd0, 8'h80, 1'b0, 1'b0);
      finish_op("post");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
